// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes stage: substitutes LANES columns per cycle through a
// shared FIPS-197 forward S-box and holds the result until ShiftRows takes it.
module sub_bytes_iter #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    input  logic [31:0] w3,
    output logic [31:0] w_0,
    output logic [31:0] w_1,
    output logic [31:0] w_2,
    output logic [31:0] w_3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [1:0] COL_STEP = 2'(LANES);
    localparam logic [1:0] LAST_COL = 2'(4 - LANES);

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    fsm_e             fsm_q, fsm_d;
    logic [3:0][31:0] data_q, data_d;
    logic [1:0]       col_q, col_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [LANES-1:0][1:0]  lane_col_s;
    logic [LANES-1:0][31:0] lane_sub_s;

    // Each lane owns four S-boxes and works on column col+lane.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_col_s[g] = col_q + 2'(g);
        assign lane_sub_s[g] = sub_word(data_q[lane_col_s[g]]);
    end

    // Next-state, column counter and datapath update.
    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
        col_d  = col_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = {w3, w2, w1, w0};
                    col_d  = 2'd0;
                    fsm_d  = SUB;
                end else begin
                    fsm_d  = IDLE;
                end
            end
            SUB: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[lane_col_s[l]] = lane_sub_s[l];
                end
                col_d = col_q + COL_STEP;
                if (col_q == LAST_COL) begin
                    fsm_d = DONE;
                end else begin
                    fsm_d = SUB;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end else begin
                    fsm_d = DONE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d == SUB);
    end

    // State, data and registered status flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            data_q      <= 128'h0;
            col_q       <= 2'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            data_q      <= data_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // in_ready is held low during reset so nothing is accepted on a reset edge.
    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign w_0       = data_q[0];
    assign w_1       = data_q[1];
    assign w_2       = data_q[2];
    assign w_3       = data_q[3];

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: LANES=1 instance for protocol behaviour,
// plus LANES=2 and LANES=4 instances for the multi-lane latency check.
module tb_sub_bytes_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] w0_i = 32'h0, w1_i = 32'h0, w2_i = 32'h0, w3_i = 32'h0;

    logic [31:0] u1_w0, u1_w1, u1_w2, u1_w3;
    logic [31:0] u2_w0, u2_w1, u2_w2, u2_w3;
    logic [31:0] u4_w0, u4_w1, u4_w2, u4_w3;
    logic        u1_ir, u1_ov, u1_busy;
    logic        u2_ir, u2_ov, u2_busy;
    logic        u4_ir, u4_ov, u4_busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_b [4] = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
    logic [31:0] r1 [4];
    logic [31:0] r2 [4];
    logic [31:0] r4 [4];
    int l1, l2, l4, lat;

    always #5 clk = ~clk;

    sub_bytes_iter #(.LANES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u1_ir),
        .w0(w0_i), .w1(w1_i), .w2(w2_i), .w3(w3_i),
        .w_0(u1_w0), .w_1(u1_w1), .w_2(u1_w2), .w_3(u1_w3),
        .out_valid(u1_ov), .out_ready(out_ready), .busy(u1_busy)
    );

    sub_bytes_iter #(.LANES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u2_ir),
        .w0(w0_i), .w1(w1_i), .w2(w2_i), .w3(w3_i),
        .w_0(u2_w0), .w_1(u2_w1), .w_2(u2_w2), .w_3(u2_w3),
        .out_valid(u2_ov), .out_ready(out_ready), .busy(u2_busy)
    );

    sub_bytes_iter #(.LANES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u4_ir),
        .w0(w0_i), .w1(w1_i), .w2(w2_i), .w3(w3_i),
        .w_0(u4_w0), .w_1(u4_w1), .w_2(u4_w2), .w_3(u4_w3),
        .out_valid(u4_ov), .out_ready(out_ready), .busy(u4_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a state for one capture edge; returns on the negedge after it.
    task automatic capture(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        @(negedge clk);
        w0_i = a; w1_i = b; w2_i = c; w3_i = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges after capture until u1 shows out_valid; -1 if it never does.
    task automatic wait_u1(input int maxc, output int l);
        l = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (u1_ov) begin
                l = c;
                break;
            end
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_in_ready_low", 32'(u1_ir), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_w0", u1_w0, 32'h0);
        chk("rst_w1", u1_w1, 32'h0);
        chk("rst_w2", u1_w2, 32'h0);
        chk("rst_w3", u1_w3, 32'h0);
        chk("rst_out_valid", 32'(u1_ov), 32'd0);
        chk("rst_busy", 32'(u1_busy), 32'd0);
        chk("rst_in_ready", 32'(u1_ir), 32'd1);

        // All-zero state
        capture(32'h0, 32'h0, 32'h0, 32'h0);
        chk("zero_busy", 32'(u1_busy), 32'd1);
        chk("zero_in_ready", 32'(u1_ir), 32'd0);
        wait_u1(10, lat);
        chk("zero_latency", 32'(lat), 32'd4);
        chk("zero_w0", u1_w0, 32'h63636363);
        chk("zero_w1", u1_w1, 32'h63636363);
        chk("zero_w2", u1_w2, 32'h63636363);
        chk("zero_w3", u1_w3, 32'h63636363);
        out_ready = 1'b1;
        @(negedge clk);
        chk("zero_hs_out_valid", 32'(u1_ov), 32'd0);
        chk("zero_hs_in_ready", 32'(u1_ir), 32'd1);

        // FIPS-197 Appendix B round 1 on all lane counts, out_ready already high
        capture(32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808);
        l1 = -1; l2 = -1; l4 = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (u1_ov && l1 < 0) begin l1 = c; r1 = '{u1_w0, u1_w1, u1_w2, u1_w3}; end
            if (u2_ov && l2 < 0) begin l2 = c; r2 = '{u2_w0, u2_w1, u2_w2, u2_w3}; end
            if (u4_ov && l4 < 0) begin l4 = c; r4 = '{u4_w0, u4_w1, u4_w2, u4_w3}; end
        end
        chk("appb_lat_l1", 32'(l1), 32'd4);
        chk("appb_lat_l2", 32'(l2), 32'd2);
        chk("appb_lat_l4", 32'(l4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("appb_l1_w%0d", k), r1[k], exp_b[k]);
            chk($sformatf("appb_l2_w%0d", k), r2[k], exp_b[k]);
            chk($sformatf("appb_l4_w%0d", k), r4[k], exp_b[k]);
        end
        chk("appb_consumed", 32'(u1_ov), 32'd0);
        out_ready = 1'b0;

        // Byte map under 10 cycles of backpressure
        capture(32'h00010203, 32'h53ff0000, 32'h0, 32'h0);
        wait_u1(10, lat);
        chk("bmap_latency", 32'(lat), 32'd4);
        chk("bmap_w2", u1_w2, 32'h63636363);
        chk("bmap_w3", u1_w3, 32'h63636363);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_w0_%0d", i), u1_w0, 32'h637c777b);
            chk($sformatf("bp_w1_%0d", i), u1_w1, 32'hed166363);
            chk($sformatf("bp_out_valid_%0d", i), 32'(u1_ov), 32'd1);
            chk($sformatf("bp_in_ready_%0d", i), 32'(u1_ir), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_out_valid", 32'(u1_ov), 32'd0);
        chk("bp_hs_in_ready", 32'(u1_ir), 32'd1);

        // in_valid held high with different data while busy
        @(negedge clk);
        w0_i = 32'h193de3be; w1_i = 32'ha0f4e22b; w2_i = 32'h9ac68d2a; w3_i = 32'he9f84808;
        in_valid = 1'b1;
        @(negedge clk);
        w0_i = 32'h00010203; w1_i = 32'h53ff0000; w2_i = 32'h0; w3_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("hold_early_out_valid", 32'(u1_ov), 32'd0);
        @(negedge clk);
        chk("hold_out_valid", 32'(u1_ov), 32'd1);
        chk("hold_w0", u1_w0, exp_b[0]);
        chk("hold_w1", u1_w1, exp_b[1]);
        chk("hold_w2", u1_w2, exp_b[2]);
        chk("hold_w3", u1_w3, exp_b[3]);
        @(negedge clk);
        chk("hold_idle_out_valid", 32'(u1_ov), 32'd0);
        chk("hold_idle_in_ready", 32'(u1_ir), 32'd1);
        chk("hold_idle_busy", 32'(u1_busy), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_second_busy", 32'(u1_busy), 32'd1);
        chk("hold_second_in_ready", 32'(u1_ir), 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_second_early", 32'(u1_ov), 32'd0);
        @(negedge clk);
        chk("hold_second_out_valid", 32'(u1_ov), 32'd1);
        chk("hold_second_w0", u1_w0, 32'h637c777b);
        chk("hold_second_w1", u1_w1, 32'hed166363);
        chk("hold_second_w2", u1_w2, 32'h63636363);
        @(negedge clk);
        chk("hold_second_consumed", 32'(u1_ov), 32'd0);
        out_ready = 1'b0;

        // Reset in the second SUB cycle discards the block
        capture(32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808);
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_in_ready_low", 32'(u1_ir), 32'd0);
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(u1_ov), 32'd0);
        chk("mid_rst_busy", 32'(u1_busy), 32'd0);
        chk("mid_rst_w0", u1_w0, 32'h0);
        chk("mid_rst_w1", u1_w1, 32'h0);
        chk("mid_rst_w2", u1_w2, 32'h0);
        chk("mid_rst_w3", u1_w3, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(u1_ir), 32'd1);
        chk("post_rst_out_valid", 32'(u1_ov), 32'd0);
        capture(32'h0, 32'h0, 32'h0, 32'h0);
        wait_u1(10, lat);
        chk("post_rst_latency", 32'(lat), 32'd4);
        chk("post_rst_w0", u1_w0, 32'h63636363);
        chk("post_rst_w3", u1_w3, 32'h63636363);
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_hs", 32'(u1_ov), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative SubBytes stage for the AES encryption datapath. It accepts a 128-bit state as four 32-bit column words and applies the FIPS-197 S-box to every byte over several cycles, using a parameterised number of column lanes. It then holds the result for the ShiftRows stage directly downstream. Byte ordering matches the rest of the encryption modules: word wN is column N, and bits [31:24] hold row 0 down to bits [7:0] for row 3.

## Interface

- LANES, default 1: columns substituted per cycle; legal values 1, 2, 4 (4 S-box instances per lane).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream (AddRoundKey) presents a state on w0..w3.
- in_ready  output  1  block can accept a state this cycle.
- w0, w1, w2, w3  input  32 each  input state columns 0..3.
- w_0, w_1, w_2, w_3  output  32 each  substituted columns 0..3, fed to ShiftRows w0..w3.
- out_valid  output  1  w_0..w_3 hold a complete SubBytes result.
- out_ready  input  1  downstream consumes the result this cycle.
- busy  output  1  substitution in progress (state SUB).

## Operation

- One clock domain and one synchronous active-high reset, as already decided.
- Internal 128-bit state register; w_0..w_3 are driven directly from it.
- Column counter col is 2 bits wide. It advances by LANES per cycle and wraps modulo 4.
- S-box: a combinational 256-entry FIPS-197 forward table. There are 4*LANES instances, shared across columns by col.
- FSM states:
  - IDLE: in_ready=1. If in_valid=1, capture w0..w3 into the state register, set col=0 and go to SUB. Otherwise stay.
  - SUB: replace columns col..col+LANES-1 with their S-box images and advance col by LANES. When the last column group is written (col+LANES==4), go to DONE.
  - DONE: out_valid=1. If out_ready=1, go to IDLE. Otherwise hold the state register and out_valid unchanged.
- in_ready=0 in SUB and DONE; the block never accepts a new state while one is held.
- out_valid and busy are registered (decoded from the state register); in_ready is decoded from state and forced 0 while rst=1.
- In SUB, w_0..w_3 show partially substituted data. Consumers sample only when out_valid=1.
- in_valid is ignored outside IDLE. Input words need only be stable on the capture edge.
- rst=1 (including mid-SUB or during DONE): on the next edge, state goes to IDLE, col=0, the state register is 0 and any in-flight block is discarded.

## Timing

- Reset values: w_0..w_3=0, out_valid=0, busy=0, in_ready=1 from the first cycle after rst deasserts.
- Capture edge E0, when in_valid and in_ready are both 1: busy=1 from E0.
- Substitution edges are E1..E(4/LANES). DONE is entered on edge E(4/LANES), and out_valid=1 in the following cycle.
- Latency from capture edge to out_valid: 4, 2 or 1 cycles for LANES=1, 2 or 4.
- Handshake edge with out_valid and out_ready both 1: out_valid=0 and in_ready=1 in the next cycle. There is no same-cycle accept, so the minimum initiation interval is 4/LANES+2 cycles.
- If out_ready is already 1 when out_valid rises, the result is consumed on the first DONE edge.
- Backpressure holds w_0..w_3 bit-stable for any number of cycles.

## Test plan

- Reset then zero state: w0..w3=32'h00000000 with in_valid pulse. Expect out_valid exactly 4 cycles after capture (LANES=1), with w_0..w_3=32'h63636363.
- FIPS-197 Appendix B round 1: w0=193de3be, w1=a0f4e22b, w2=9ac68d2a, w3=e9f84808. Expect w_0=d42711ae, w_1=e0bf98f1, w_2=b8b45de5, w_3=1e415230. Run for LANES=1, 2 and 4 with latencies 4, 2 and 1.
- Byte map and backpressure: w0=00010203, w1=53ff0000, w2=w3=0, out_ready=0 for 10 cycles. Expect w_0=637c777b and w_1=ed166363, stable, with out_valid=1 and in_ready=0 throughout. After out_ready=1, expect out_valid=0 and in_ready=1 the next cycle.
- in_valid held high with new data during SUB/DONE: expect it ignored and the first result intact. The second block is captured on the first IDLE cycle, giving an interval of 6 cycles (LANES=1).
- rst asserted at cycle 2 of SUB: next cycle expect out_valid=0, busy=0, w_0..w_3=0 and in_ready=1 after release. A fresh all-00 block then yields 63636363 with normal latency.
